vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator: horizontal/vertical pixel counters, sync pulses, active-video flag and frame/line markers for the pixel pipeline and the video DAC.
- Generalises the fixed 640x480 controller: any mode via parameters, selectable sync polarity, integer pixel-clock divider and run/stop control that always halts on a frame boundary.
- Sits between the clock source and the frame-buffer read / pixel-colour logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
CLK_DIV, 1, vgaclk cycles per pixel (1..16)
CW, 11, counter width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL

Ports:
vgaclk  in  1  pixel/system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  1 = generate video; 0 = stop at end of current frame
pix_tick  out  1  one-vgaclk pulse per pixel advance
counter_H  out  CW  current pixel column, 0..H_TOTAL-1
counter_V  out  CW  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per HS_POL
vsync  out  1  vertical sync, polarity per VS_POL
vga_sync  out  1  hsync AND vsync (composite, active-low modes)
vga_blank  out  1  1 = inside visible area (DAC blank_n)
line_start  out  1  1-tick pulse when counter_H = 0
frame_start  out  1  1-tick pulse when counter_H = 0 and counter_V = 0
running  out  1  1 while state is RUN or DRAIN

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default). Counters wrap at TOTAL-1 -> 0; value TOTAL never appears.
- Reset (async, any time, including mid-frame): state IDLE; divider = 0; counter_H = counter_V = 0; pix_tick = line_start = frame_start = running = 0; vga_blank = 0; hsync = ~HS_POL, vsync = ~VS_POL (deasserted); vga_sync = hsync & vsync.
- Divider: counts 0..CLK_DIV-1 only in RUN/DRAIN; pix_tick = 1 in the vgaclk cycle where divider = CLK_DIV-1. CLK_DIV = 1 -> pix_tick high every cycle while running.
- Counters advance only on pix_tick: counter_H increments; at H_TOTAL-1 it wraps to 0 and counter_V increments (wrapping at V_TOTAL-1).
- Every timing output is registered and reflects the counter values present in the same cycle (computed from next-state counters), so it needs no external delay alignment.
  - hsync asserted iff H_ACTIVE+H_FP <= counter_H < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP <= counter_V < V_ACTIVE+V_FP+V_SYNC.
  - vga_blank = (counter_H < H_ACTIVE) & (counter_V < V_ACTIVE) while running, else 0.
  - line_start / frame_start: high for exactly one pix_tick cycle, the cycle pix_tick fires with the counters at the stated position.
- State machine:
  - IDLE: counters held at (0,0), outputs at reset values. run = 1 -> RUN next cycle; first pix_tick with frame_start = 1 follows CLK_DIV cycles later.
  - RUN: run = 0 -> DRAIN. Frame in progress is not truncated.
  - DRAIN: keeps generating. The pix_tick that wraps (H_TOTAL-1, V_TOTAL-1) -> (0,0) moves to IDLE with no frame_start pulse. run = 1 again during DRAIN -> RUN with no visible glitch.
  - run deasserted exactly on the wrapping pix_tick cycle -> DRAIN, so one full further frame is produced.
- Parameter violations (zero-width field, CLK_DIV outside 1..16, CW too small) are elaboration errors, not runtime behaviour.

Test Plan:
- Defaults, CLK_DIV=1, run=1 after reset -> frame_start every 420000 cycles; line_start every 800; hsync low exactly for counter_H 656..751; vsync low for counter_V 490..491; vga_blank high 640x480 = 307200 cycles per frame.
- CLK_DIV=2 -> pix_tick every 2nd cycle; counters hold between ticks; frame period 840000 cycles; sync positions unchanged in pixel units.
- HS_POL=1, VS_POL=1 -> hsync high only at counter_H 656..751, vsync high only at lines 490..491; both low while in IDLE and after reset.
- run dropped at (100,200) -> running stays 1 until the wrap from (799,524); then counters hold at (0,0) with vga_blank=0 and no further pix_tick. run reasserted at (50,50) during DRAIN -> continuous output, next frame_start on schedule.
- rst asserted asynchronously at (300,300) between clock edges -> outputs take reset values immediately, before the next edge; after release with run=1, the frame restarts from (0,0) with frame_start.
- Small mode (H 8/2/2/2, V 4/1/1/1) -> H_TOTAL=14, V_TOTAL=7; counter_H never reaches 14; counter_V wraps 6 -> 0; frame_start every 98 ticks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. Produces pixel/line counters,
//   horizontal/vertical sync (selectable polarity), the active-video flag and
//   line/frame start markers. An integer pixel-clock divider slows the raster
//   down to CLK_DIV vgaclk cycles per pixel. The run input starts the raster
//   and, when dropped, lets the frame in progress finish before halting at
//   (0,0).
//
// Ports
//   vgaclk      in   pixel/system clock, rising edge
//   rst         in   asynchronous active-high reset
//   run         in   1 = generate video, 0 = stop at the end of this frame
//   pix_tick    out  one-vgaclk pulse per pixel advance
//   counter_H   out  current pixel column, 0..H_TOTAL-1
//   counter_V   out  current line, 0..V_TOTAL-1
//   hsync       out  horizontal sync, asserted level = HS_POL
//   vsync       out  vertical sync, asserted level = VS_POL
//   vga_sync    out  hsync AND vsync
//   vga_blank   out  1 inside the visible area (DAC blank_n)
//   line_start  out  pix_tick cycle with counter_H = 0
//   frame_start out  pix_tick cycle with counter_H = 0 and counter_V = 0
//   running     out  1 while generating (RUN or DRAIN)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 1,
  parameter int CW       = 11
) (
  input  logic          vgaclk,
  input  logic          rst,
  input  logic          run,
  output logic          pix_tick,
  output logic [CW-1:0] counter_H,
  output logic [CW-1:0] counter_V,
  output logic          hsync,
  output logic          vsync,
  output logic          vga_sync,
  output logic          vga_blank,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  // Illegal parameter sets are rejected at elaboration.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal timing fields must be non-zero");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: vertical timing fields must be non-zero");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end
  if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    divider_q, divider_d;
  logic [CW-1:0] counter_h_q, counter_h_d;
  logic [CW-1:0] counter_v_q, counter_v_d;
  logic          pix_tick_q, pix_tick_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          vga_sync_q, vga_sync_d;
  logic          vga_blank_q, vga_blank_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          running_q, running_d;
  logic          h_wrap, v_wrap, frame_wrap;

  always_comb begin
    state_d       = state_q;
    divider_d     = '0;
    counter_h_d   = counter_h_q;
    counter_v_d   = counter_v_q;
    h_wrap        = (counter_h_q == H_LAST);
    v_wrap        = (counter_v_q == V_LAST);
    // pix_tick_q marks the cycle whose closing edge advances the counters.
    frame_wrap    = pix_tick_q & h_wrap & v_wrap;

    unique case (state_q)
      IDLE:    if (run) state_d = RUN;
      RUN:     if (!run) state_d = DRAIN;
      DRAIN: begin
        if (run)             state_d = RUN;
        else if (frame_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d != IDLE);

    // The divider restarts from 0 on every IDLE -> RUN entry, so the first
    // pixel tick lands CLK_DIV cycles after run is sampled.
    if (running_d && (state_q != IDLE)) begin
      divider_d = (divider_q == DIV_LAST) ? 4'd0 : divider_q + 4'd1;
    end

    if (pix_tick_q) begin
      if (h_wrap) begin
        counter_h_d = '0;
        counter_v_d = v_wrap ? '0 : counter_v_q + C_ONE;
      end else begin
        counter_h_d = counter_h_q + C_ONE;
      end
    end

    // All outputs are computed from the next-cycle counters so that they line
    // up with counter_H/counter_V when registered.
    pix_tick_d    = running_d & (divider_d == DIV_LAST);
    hsync_d       = (running_d && counter_h_d >= HS_START && counter_h_d < HS_END)
                    ? HS_ON : ~HS_ON;
    vsync_d       = (running_d && counter_v_d >= VS_START && counter_v_d < VS_END)
                    ? VS_ON : ~VS_ON;
    vga_sync_d    = hsync_d & vsync_d;
    vga_blank_d   = running_d & (counter_h_d < H_VIS) & (counter_v_d < V_VIS);
    line_start_d  = pix_tick_d & (counter_h_d == '0);
    frame_start_d = pix_tick_d & (counter_h_d == '0) & (counter_v_d == '0);
  end

  always_ff @(posedge vgaclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      divider_q     <= '0;
      counter_h_q   <= '0;
      counter_v_q   <= '0;
      pix_tick_q    <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      vga_sync_q    <= ~HS_ON & ~VS_ON;
      vga_blank_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      divider_q     <= divider_d;
      counter_h_q   <= counter_h_d;
      counter_v_q   <= counter_v_d;
      pix_tick_q    <= pix_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vga_sync_q    <= vga_sync_d;
      vga_blank_q   <= vga_blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign counter_H   = counter_h_q;
  assign counter_V   = counter_v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_sync    = vga_sync_q;
  assign vga_blank   = vga_blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule
